// File: rtl/pc_sn_15_4_checker.sv
// Exhaustive sweep checker for a 15-input parallel (popcount) counter.
// Optional macro PC_CHK_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module pc_sn_15_4_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [14:0] LAST_VEC      = 15'h7FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [14:0] dut_in,
    input  logic [3:0]  dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_cnt,
    output logic [14:0] fail_vec,
    output logic [3:0]  fail_got
);

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StCheck,
        StDone
    } state_e;

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES);

    state_e      r_state, w_state_d;
    logic [14:0] r_vec, w_vec_d;
    logic [14:0] r_dut_in, w_dut_in_d;
    logic [3:0]  r_settle, w_settle_d;
    logic [7:0]  r_err, w_err_d;
    logic [14:0] r_fail_vec, w_fail_vec_d;
    logic [3:0]  r_fail_got, w_fail_got_d;
    logic        r_done, w_done_d;
    logic        r_pass, w_pass_d;
    logic [3:0]  w_golden;
    logic        w_mismatch;

    always_comb begin
        w_golden = 4'd0;
        for (int i = 0; i < 15; i++) begin
            w_golden = w_golden + {3'd0, r_dut_in[i]};
        end
    end

    assign w_mismatch = (dut_out != w_golden);

    always_comb begin
        w_state_d    = r_state;
        w_vec_d      = r_vec;
        w_dut_in_d   = r_dut_in;
        w_settle_d   = r_settle;
        w_err_d      = r_err;
        w_fail_vec_d = r_fail_vec;
        w_fail_got_d = r_fail_got;
        w_done_d     = r_done;
        w_pass_d     = r_pass;

        unique case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_d    = StDrive;
                    w_vec_d      = 15'd0;
                    w_err_d      = 8'd0;
                    w_fail_vec_d = 15'd0;
                    w_fail_got_d = 4'd0;
                    w_done_d     = 1'b0;
                    w_pass_d     = 1'b0;
                end
            end
            StDrive: begin
                w_dut_in_d = r_vec;
                w_settle_d = SettleLoad;
                w_state_d  = StSettle;
            end
            StSettle: begin
                w_settle_d = r_settle - 4'd1;
                if (r_settle <= 4'd1) begin
                    w_state_d = StCheck;
                end
            end
            StCheck: begin
                if (w_mismatch) begin
                    if (r_err != 8'hFF) begin
                        w_err_d = r_err + 8'd1;
                    end
                    if (r_err == 8'd0) begin
                        w_fail_vec_d = r_dut_in;
                        w_fail_got_d = dut_out;
                    end
                end
`ifdef PC_CHK_STOP_ON_FAIL_EN
                if (w_mismatch) begin
                    w_state_d = StDone;
                    w_done_d  = 1'b1;
                    w_pass_d  = 1'b0;
                end else if (r_vec == LAST_VEC) begin
                    w_state_d = StDone;
                    w_done_d  = 1'b1;
                    w_pass_d  = (r_err == 8'd0);
                end else begin
                    w_vec_d   = r_vec + 15'd1;
                    w_state_d = StDrive;
                end
`else
                if (r_vec == LAST_VEC) begin
                    w_state_d = StDone;
                    w_done_d  = 1'b1;
                    w_pass_d  = (r_err == 8'd0) && !w_mismatch;
                end else begin
                    w_vec_d   = r_vec + 15'd1;
                    w_state_d = StDrive;
                end
`endif
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_vec      <= 15'd0;
            r_dut_in   <= 15'd0;
            r_settle   <= 4'd0;
            r_err      <= 8'd0;
            r_fail_vec <= 15'd0;
            r_fail_got <= 4'd0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_vec      <= w_vec_d;
            r_dut_in   <= w_dut_in_d;
            r_settle   <= w_settle_d;
            r_err      <= w_err_d;
            r_fail_vec <= w_fail_vec_d;
            r_fail_got <= w_fail_got_d;
            r_done     <= w_done_d;
            r_pass     <= w_pass_d;
        end
    end

    assign dut_in   = r_dut_in;
    assign busy     = (r_state == StDrive) || (r_state == StSettle) || (r_state == StCheck);
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err;
    assign fail_vec = r_fail_vec;
    assign fail_got = r_fail_got;

endmodule

// File: tb/tb_pc_sn_15_4_checker.sv
// Randomized bench for pc_sn_15_4_checker: a fault-injecting counter model drives dut_out and a
// per-sweep reference computes the expected verdict from the popcount rule.
`timescale 1ns/1ps
module tb_pc_sn_15_4_checker;

    localparam int unsigned S    = 2;
    localparam int          NVEC = 512;
    localparam logic [14:0] LAST = 15'h01FF;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [14:0] dut_in;
    logic [3:0]  dut_out;
    logic        busy, done, pass;
    logic [7:0]  err_cnt;
    logic [14:0] fail_vec;
    logic [3:0]  fail_got;

    logic        start_s = 1'b0;
    logic [14:0] dut_in_s;
    logic [3:0]  dut_out_s;
    logic        busy_s, done_s, pass_s;
    logic [7:0]  err_cnt_s;
    logic [14:0] fail_vec_s;
    logic [3:0]  fail_got_s;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          fault_tab [NVEC];  // -1: behave as a correct counter
    int          tab_gen  = 0;
    int          busy_cycles = 0;
    logic        busy_prev = 1'b0;
    logic [14:0] seq_q [$];

    always #5 clk = ~clk;

    pc_sn_15_4_checker #(.SETTLE_CYCLES(S), .LAST_VEC(LAST)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec),
        .fail_got(fail_got)
    );

    pc_sn_15_4_checker #(.SETTLE_CYCLES(1), .LAST_VEC(15'h0003)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .dut_in(dut_in_s), .dut_out(dut_out_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_cnt_s),
        .fail_vec(fail_vec_s), .fail_got(fail_got_s)
    );

    assign dut_out_s = 4'($countones(dut_in_s));

    always @(dut_in or tab_gen) begin
        if (fault_tab[dut_in[8:0]] >= 0) dut_out = 4'(fault_tab[dut_in[8:0]]);
        else                             dut_out = 4'($countones(dut_in));
    end

    // The first busy cycle still shows the previous dut_in, so it is not recorded.
    always @(negedge clk) begin
        if (busy) begin
            busy_cycles++;
            if (busy_prev && (seq_q.size() == 0 || seq_q[$] != dut_in)) seq_q.push_back(dut_in);
        end
        busy_prev = busy;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_correct();
        for (int v = 0; v < NVEC; v++) fault_tab[v] = -1;
        tab_gen++;
    endtask

    task automatic set_stuck0();
        for (int v = 0; v < NVEC; v++) fault_tab[v] = 0;
        tab_gen++;
    endtask

    task automatic set_random(input int n_faults);
        for (int v = 0; v < NVEC; v++) fault_tab[v] = -1;
        for (int k = 0; k < n_faults; k++) begin
            fault_tab[$urandom_range(NVEC - 1, 0)] = int'($urandom_range(15, 0));
        end
        tab_gen++;
    endtask

    task automatic model_sweep(output int e_err, output int e_fv, output int e_fg,
                               output int e_n);
        int mism;
        mism  = 0;
        e_fv  = 0;
        e_fg  = 0;
        e_n   = NVEC;
        for (int v = 0; v < NVEC; v++) begin
            int got;
            got = (fault_tab[v] >= 0) ? fault_tab[v] : $countones(v);
            if (got != $countones(v)) begin
                if (mism == 0) begin
                    e_fv = v;
                    e_fg = got;
                end
                mism++;
`ifdef PC_CHK_STOP_ON_FAIL_EN
                e_n = v + 1;
                break;
`endif
            end
        end
        e_err = (mism > 255) ? 255 : mism;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        seq_q.delete();
        busy_cycles = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_sweep(input string tag);
        int e_err, e_fv, e_fg, e_n, cyc, bad;
        model_sweep(e_err, e_fv, e_fg, e_n);
        pulse_start();
        cyc = 0;
        while (!done && cyc < NVEC * (S + 2) + 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_pass"}, pass, (e_err == 0) ? 1 : 0);
        check_eq({tag, "_err_cnt"}, err_cnt, e_err);
        check_eq({tag, "_fail_vec"}, fail_vec, e_fv);
        check_eq({tag, "_fail_got"}, fail_got, e_fg);
        check_eq({tag, "_dut_in_hold"}, dut_in, e_n - 1);
        check_eq({tag, "_busy_cycles"}, busy_cycles, e_n * (S + 2));
        check_eq({tag, "_seq_len"}, seq_q.size(), e_n);
        bad = -1;
        foreach (seq_q[i]) if (bad < 0 && seq_q[i] != 15'(i)) bad = i;
        if (bad >= 0) check_eq({tag, "_seq_val"}, seq_q[bad], bad);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_dut_in"}, dut_in, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pass"}, pass, 0);
        check_eq({tag, "_err_cnt"}, err_cnt, 0);
        check_eq({tag, "_fail_vec"}, fail_vec, 0);
        check_eq({tag, "_fail_got"}, fail_got, 0);
    endtask

    initial begin
        int cyc, nb;
        set_correct();
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("post_reset_idle");

        set_correct();
        run_sweep("correct");
        set_stuck0();
        run_sweep("stuck0");
        set_correct();
        fault_tab[NVEC - 1] = 14;
        tab_gen++;
        run_sweep("last_fault");
        set_correct();
        run_sweep("correct_from_done");
        for (int r = 0; r < 3; r++) begin
            set_random(int'($urandom_range(6, 0)));
            run_sweep($sformatf("rand%0d", r));
        end
        set_random(400);
        run_sweep("rand_dense");

        // Abandon a sweep mid-way and confirm the next one restarts at vector 0.
        set_stuck0();
        pulse_start();
        cyc = 0;
        while (dut_in != 15'h0100 && cyc < NVEC * (S + 2)) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_reach_0100", dut_in, 15'h0100);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        set_correct();
        run_sweep("after_reset");

        // Small instance: start held high, 4 vectors at 3 cycles each, then immediate restart.
        @(posedge clk);
        #1 start_s = 1'b1;
        cyc = 0;
        nb  = 0;
        while (!done_s && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy_s) nb++;
        end
        check_eq("small_done", done_s, 1);
        check_eq("small_busy_cycles", nb, 12);
        check_eq("small_pass", pass_s, 1);
        check_eq("small_err_cnt", err_cnt_s, 0);
        check_eq("small_dut_in", dut_in_s, 3);
        @(negedge clk);
        check_eq("small_restart_busy", busy_s, 1);
        check_eq("small_restart_done", done_s, 0);
        start_s = 1'b0;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/pc_sn_15_4_checker.md
PC_SN_15_4_CHECKER -- requirements
Module: pc_sn_15_4_checker

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, meaning idle cycles between driving a vector and sampling the counter result (legal range 1..15).
REQ-002 The block SHALL have parameter LAST_VEC, default 15'h7FFF, meaning the final vector of the sweep (sweep covers 0..LAST_VEC inclusive).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, level-sampled request to begin a sweep.
REQ-006 The block SHALL have port dut_in, output, 15, the vector driven to the parallel counter's in port.
REQ-007 The block SHALL have port dut_out, input, 4, the parallel counter's out port.
REQ-008 The block SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1, high while the block is in DONE.
REQ-010 The block SHALL have port pass, output, 1, high in DONE when err_cnt is 0; low otherwise.
REQ-011 The block SHALL have port err_cnt, output, 8, saturating mismatch count.
REQ-012 The block SHALL have port fail_vec, output, 15, first vector that mismatched.
REQ-013 The block SHALL have port fail_got, output, 4, dut_out value captured at the first mismatch.

Function
REQ-014 The block SHALL implement FSM states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-015 IDLE/DONE with start=1 SHALL move to DRIVE next cycle, clearing vector register to 0, err_cnt, fail_vec, fail_got, pass and done.
REQ-016 start SHALL be ignored in DRIVE, SETTLE and CHECK.
REQ-017 DRIVE SHALL present the current vector on dut_in (registered), load the settle counter with SETTLE_CYCLES, and go to SETTLE.
REQ-018 SETTLE SHALL decrement the settle counter each cycle and go to CHECK when it reaches 1; per-vector cost is exactly SETTLE_CYCLES+2 cycles.
REQ-019 CHECK SHALL compare dut_out against the golden popcount of dut_in (0..15, 4 bits, computed from the registered vector).
REQ-020 On mismatch, err_cnt SHALL increment, saturating at 255; fail_vec/fail_got SHALL be captured only when err_cnt was 0 before the increment.
REQ-021 After CHECK, if vector equals LAST_VEC the FSM SHALL go to DONE; otherwise vector increments by 1 and the FSM goes to DRIVE (no wrap past LAST_VEC).
REQ-022 busy SHALL be high in DRIVE, SETTLE, CHECK; done and pass SHALL be valid only in DONE and be registered outputs.
REQ-023 dut_in SHALL hold its last value in DONE and IDLE.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE and dut_in=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0, fail_got=0, settle counter=0, vector=0.
REQ-025 Reset mid-sweep SHALL abandon the sweep; the next start SHALL restart from vector 0.

Configuration
REQ-026 Macro PC_CHK_STOP_ON_FAIL_EN defined: first mismatch in CHECK SHALL go directly to DONE with err_cnt=1 and the failing vector held on dut_in.
REQ-027 Macro PC_CHK_STOP_ON_FAIL_EN undefined: the sweep SHALL always run to LAST_VEC, counting all mismatches.

Verification
REQ-028 Correct 15-input counter connected, default params, 1-cycle start pulse -> busy for 32768*4 cycles, then done=1, pass=1, err_cnt=0.
REQ-029 dut_out stuck at 4'd0, macro undefined -> done=1, pass=0, err_cnt=255 (saturated), fail_vec=15'h0001, fail_got=4'd0.
REQ-030 Faulty model returning 4'd14 only for 15'h7FFF -> err_cnt=1, fail_vec=15'h7FFF, fail_got=4'd14, pass=0.
REQ-031 rst_n pulsed low while dut_in=15'h0100 -> all outputs 0 asynchronously; subsequent start -> dut_in sequence restarts at 15'h0000.
REQ-032 Macro defined, dut_out stuck at 4'd0 -> DONE after CHECK of vector 15'h0001, err_cnt=1, dut_in holds 15'h0001.
REQ-033 start held high throughout sweep, LAST_VEC=15'h0003 -> exactly 4 vectors checked, then DONE; start still high in DONE restarts a sweep next cycle.
